// File: rtl/round_seq_if.sv
// round_seq_if
//  Groups the reaction-timer round sequencer's button inputs and status outputs.
//  Ports (as seen from the sequencer, modport slave):
//   start, clr, btn1, btn2  in   raw active-high buttons
//   flag[3:0]               out  round code (0 idle, 1 running, 2 P1, 3 P2, 4 timeout)
//   led[2:0]                out  [0] armed, [1] foul, [2] GO lamp
//   round_done              out  one-cycle pulse on entry to a result state
//   tie                     out  both players accepted in the same cycle
//  The master modport is the button/lamp side (board or testbench).
interface round_seq_if;
    logic       start;
    logic       clr;
    logic       btn1;
    logic       btn2;
    logic [3:0] flag;
    logic [2:0] led;
    logic       round_done;
    logic       tie;

    modport master (
        output start, clr, btn1, btn2,
        input  flag, led, round_done, tie
    );

    modport slave (
        input  start, clr, btn1, btn2,
        output flag, led, round_done, tie
    );
endinterface

// File: rtl/round_seq.sv
// round_seq
//  Round sequencer for the reaction timer. A start press arms a round, a
//  pseudo-random delay later the GO lamp lights, and the first accepted
//  player button (or a timeout) decides the result, which is held until
//  clear or a new start.
//  Ports:
//   clk  in  system clock (1 kHz tick), all logic on posedge
//   rst  in  synchronous reset, active-low
//   bus  round_seq_if.slave: start/clr/btn1/btn2 in, flag/led/round_done/tie out
module round_seq #(
    parameter int MIN_DELAY  = 1000,
    parameter int RAND_BITS  = 11,
    parameter int TIMEOUT    = 999,
    parameter int DEB_CYCLES = 8
) (
    input logic        clk,
    input logic        rst,
    round_seq_if.slave bus
);
    // Delay counter holds MIN_DELAY plus the largest random add-on.
    localparam int DLY_W = $clog2(MIN_DELAY + (1 << RAND_BITS) + 1);
    localparam int GO_W  = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT, GO, HIT1, HIT2, FOUL1, FOUL2, TMO
    } state_t;

    state_t           state, state_n;
    logic [DLY_W-1:0] dly, dly_n;
    logic [GO_W-1:0]  go_cnt, go_cnt_n;
    logic             tie, tie_n;
    logic [3:0]       flag, flag_n;
    logic [2:0]       led, led_n;
    logic             done, done_n;
    logic [15:0]      lfsr;

    logic [3:0]       raw, sync1, sync2, deb, deb_q, press;
    logic [CNT_W-1:0] cnt [4];
    logic             start_p, clr_p, b1_p, b2_p;

    function automatic logic is_result(input state_t s);
        return s inside {HIT1, HIT2, FOUL1, FOUL2, TMO};
    endfunction

    assign raw = {bus.btn2, bus.btn1, bus.clr, bus.start};

    // Button front end: 2-FF synchroniser, then a debouncer that only flips
    // its accepted level after DEB_CYCLES consecutive samples disagree with it.
    // Any agreeing sample restarts the count, so short glitches are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the accepted level is the one-cycle press pulse.
    assign press   = deb & ~deb_q;
    assign start_p = press[0];
    assign clr_p   = press[1];
    assign b1_p    = press[2];
    assign b2_p    = press[3];

    // Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting right;
    // the non-zero seed keeps it out of the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (!rst) lfsr <= 16'hACE1;
        else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Next-state logic. Player 1 wins a same-cycle tie and the tie flag is
    // recorded alongside. A clear press overrides everything else.
    always_comb begin
        state_n  = state;
        dly_n    = dly;
        go_cnt_n = go_cnt;
        tie_n    = tie;
        case (state)
            IDLE: begin
                if (start_p) begin
                    state_n = WAIT;
                    dly_n   = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);
                end
            end
            WAIT: begin
                dly_n = dly - 1'b1;
                if (b1_p) begin
                    state_n = FOUL1;
                    tie_n   = b2_p;
                end else if (b2_p) begin
                    state_n = FOUL2;
                end else if (dly <= DLY_W'(1)) begin
                    state_n  = GO;
                    go_cnt_n = '0;
                end
            end
            GO: begin
                go_cnt_n = go_cnt + 1'b1;
                if (b1_p) begin
                    state_n = HIT1;
                    tie_n   = b2_p;
                end else if (b2_p) begin
                    state_n = HIT2;
                end else if (go_cnt == GO_W'(TIMEOUT - 1)) begin
                    state_n = TMO;
                end
            end
            default: begin
                if (start_p) begin
                    state_n = WAIT;
                    dly_n   = DLY_W'(MIN_DELAY) + DLY_W'(lfsr[RAND_BITS-1:0]);
                    tie_n   = 1'b0;
                end
            end
        endcase
        if (clr_p) begin
            state_n = IDLE;
            tie_n   = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered outputs
    // change on the same edge as the state register.
    always_comb begin
        flag_n = 4'd0;
        led_n  = 3'b000;
        case (state_n)
            WAIT:    begin flag_n = 4'd1; led_n = 3'b001; end
            GO:      begin flag_n = 4'd1; led_n = 3'b100; end
            HIT1:    begin flag_n = 4'd2; led_n = 3'b100; end
            HIT2:    begin flag_n = 4'd3; led_n = 3'b100; end
            FOUL1:   begin flag_n = 4'd2; led_n = 3'b010; end
            FOUL2:   begin flag_n = 4'd3; led_n = 3'b010; end
            TMO:     begin flag_n = 4'd4; led_n = 3'b000; end
            default: begin flag_n = 4'd0; led_n = 3'b000; end
        endcase
        done_n = is_result(state_n) && !is_result(state);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            dly    <= '0;
            go_cnt <= '0;
            tie    <= 1'b0;
            flag   <= 4'd0;
            led    <= 3'b000;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            dly    <= dly_n;
            go_cnt <= go_cnt_n;
            tie    <= tie_n;
            flag   <= flag_n;
            led    <= led_n;
            done   <= done_n;
        end
    end

    assign bus.flag       = flag;
    assign bus.led        = led;
    assign bus.round_done = done;
    assign bus.tie        = tie;
endmodule

// File: tb/tb_round_seq.sv
// tb_round_seq
//  Self-checking bench for round_seq with short simulation parameters.
//  Expected round results are queued when the deciding stimulus is driven
//  and compared when round_done is seen.
module tb_round_seq;
    localparam int MIN_DELAY  = 20;
    localparam int RAND_BITS  = 4;
    localparam int TIMEOUT    = 50;
    localparam int DEB_CYCLES = 2;
    // Raw edge set just after a falling clock edge -> result registered on the
    // (DEB_CYCLES+3)-th rising edge, seen on the following falling edge.
    localparam int LAT = DEB_CYCLES + 3;

    typedef struct packed {
        logic [3:0] flag;
        logic [2:0] led;
        logic       tie;
    } res_t;

    logic        clk;
    logic        rst;
    logic [15:0] lfsr_m;
    res_t        exp_q[$];
    res_t        exp_r;
    int          checks = 0;
    int          passes = 0;

    round_seq_if bus();

    round_seq #(
        .MIN_DELAY (MIN_DELAY),
        .RAND_BITS (RAND_BITS),
        .TIMEOUT   (TIMEOUT),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Reference LFSR tracking the one inside the DUT.
    always @(posedge clk) begin
        if (!rst) lfsr_m <= 16'hACE1;
        else      lfsr_m <= lstep(lfsr_m);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for round_done; n = falling edges taken, -1 if never seen.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.round_done !== 1'b1 && n < budget);
        if (bus.round_done !== 1'b1) n = -1;
    endtask

    // Waits for the GO lamp; ok = 0 if it never came.
    task automatic wait_go(input int budget, output bit ok);
        int n;
        n = 0;
        while (bus.led !== 3'b100 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.led === 3'b100);
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        cyc(4);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.clr = 1'b0; bus.btn1 = 1'b0; bus.btn2 = 1'b0;
        cyc(3);
        checks++; if (bus.flag !== 4'd0) $display("[TB] FAIL reset_flag: got %0d expected 0", bus.flag); else passes++;
        checks++; if (bus.led !== 3'b000) $display("[TB] FAIL reset_led: got %b expected 000", bus.led); else passes++;
        checks++; if (bus.round_done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus.round_done); else passes++;
        checks++; if (bus.tie !== 1'b0) $display("[TB] FAIL reset_tie: got %b expected 0", bus.tie); else passes++;
        rst = 1'b1;
        cyc(2);
    endtask

    task automatic test_arm_delay();
        int  k;
        int  cnt;
        logic [15:0] l;
        k = 0;
        l = lstep(lstep(lstep(lstep(lfsr_m))));
        while (l[3:0] !== 4'd5 && k < 300) begin
            cyc(1);
            k++;
            l = lstep(lstep(lstep(lstep(lfsr_m))));
        end
        checks++; if (l[3:0] !== 4'd5) $display("[TB] FAIL arm_lfsr_slot: got %0d expected 5", l[3:0]); else passes++;
        bus.start = 1'b1;
        cyc(4);
        bus.start = 1'b0;
        checks++; if (bus.flag !== 4'd0) $display("[TB] FAIL arm_early: flag %0d expected 0", bus.flag); else passes++;
        cyc(1);
        checks++; if (bus.flag !== 4'd1 || bus.led !== 3'b001) $display("[TB] FAIL arm_wait: flag %0d led %b expected 1/001", bus.flag, bus.led); else passes++;
        cnt = 0;
        while (bus.led === 3'b001 && cnt < 100) begin
            cnt++;
            cyc(1);
        end
        checks++; if (cnt !== MIN_DELAY + 5) $display("[TB] FAIL arm_len: got %0d expected %0d", cnt, MIN_DELAY + 5); else passes++;
        checks++; if (bus.flag !== 4'd1 || bus.led !== 3'b100) $display("[TB] FAIL arm_go: flag %0d led %b expected 1/100", bus.flag, bus.led); else passes++;
    endtask

    task automatic test_hit();
        int n;
        exp_q.push_back('{flag: 4'd2, led: 3'b100, tie: 1'b0});
        bus.btn1 = 1'b1;
        wait_done(20, n);
        checks++; if (n !== LAT) $display("[TB] FAIL hit_latency: got %0d expected %0d", n, LAT); else passes++;
        exp_r = exp_q.pop_front();
        checks++; if (bus.flag !== exp_r.flag || bus.led !== exp_r.led || bus.tie !== exp_r.tie)
            $display("[TB] FAIL hit_result: got %0d/%b/%b expected %0d/%b/%b", bus.flag, bus.led, bus.tie, exp_r.flag, exp_r.led, exp_r.tie); else passes++;
        cyc(1);
        checks++; if (bus.round_done !== 1'b0) $display("[TB] FAIL hit_done_pulse: got %b expected 0", bus.round_done); else passes++;
        cyc(4);
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b1;
        cyc(6);
        bus.btn2 = 1'b0;
        cyc(6);
        checks++; if (bus.flag !== 4'd2 || bus.led !== 3'b100) $display("[TB] FAIL hit_hold: flag %0d led %b expected 2/100", bus.flag, bus.led); else passes++;
    endtask

    task automatic test_foul();
        int n;
        int bad;
        press_start();
        cyc(1);
        checks++; if (bus.flag !== 4'd1 || bus.led !== 3'b001 || bus.tie !== 1'b0)
            $display("[TB] FAIL foul_rearm: flag %0d led %b tie %b expected 1/001/0", bus.flag, bus.led, bus.tie); else passes++;
        exp_q.push_back('{flag: 4'd3, led: 3'b010, tie: 1'b0});
        bus.btn2 = 1'b1;
        wait_done(20, n);
        bus.btn2 = 1'b0;
        checks++; if (n !== LAT) $display("[TB] FAIL foul_latency: got %0d expected %0d", n, LAT); else passes++;
        exp_r = exp_q.pop_front();
        checks++; if (bus.flag !== exp_r.flag || bus.led !== exp_r.led || bus.tie !== exp_r.tie)
            $display("[TB] FAIL foul_result: got %0d/%b/%b expected %0d/%b/%b", bus.flag, bus.led, bus.tie, exp_r.flag, exp_r.led, exp_r.tie); else passes++;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (bus.led[2] !== 1'b0 || bus.flag !== 4'd3) bad++;
        end
        checks++; if (bad !== 0) $display("[TB] FAIL foul_no_go: %0d bad cycles expected 0", bad); else passes++;
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        press_start();
        wait_go(60, ok);
        checks++; if (ok !== 1'b1) $display("[TB] FAIL tmo_go: led %b expected 100", bus.led); else passes++;
        exp_q.push_back('{flag: 4'd4, led: 3'b000, tie: 1'b0});
        wait_done(80, n);
        checks++; if (n !== TIMEOUT) $display("[TB] FAIL tmo_len: got %0d expected %0d", n, TIMEOUT); else passes++;
        exp_r = exp_q.pop_front();
        checks++; if (bus.flag !== exp_r.flag || bus.led !== exp_r.led || bus.tie !== exp_r.tie)
            $display("[TB] FAIL tmo_result: got %0d/%b/%b expected %0d/%b/%b", bus.flag, bus.led, bus.tie, exp_r.flag, exp_r.led, exp_r.tie); else passes++;
        cyc(1);
        checks++; if (bus.round_done !== 1'b0 || bus.flag !== 4'd4) $display("[TB] FAIL tmo_hold: done %b flag %0d expected 0/4", bus.round_done, bus.flag); else passes++;
    endtask

    task automatic test_tie_glitch();
        int n;
        int bad;
        bit ok;
        press_start();
        wait_go(60, ok);
        exp_q.push_back('{flag: 4'd2, led: 3'b100, tie: 1'b1});
        bus.btn1 = 1'b1;
        bus.btn2 = 1'b1;
        wait_done(20, n);
        checks++; if (n !== LAT) $display("[TB] FAIL tie_latency: got %0d expected %0d", n, LAT); else passes++;
        exp_r = exp_q.pop_front();
        checks++; if (bus.flag !== exp_r.flag || bus.led !== exp_r.led || bus.tie !== exp_r.tie)
            $display("[TB] FAIL tie_result: got %0d/%b/%b expected %0d/%b/%b", bus.flag, bus.led, bus.tie, exp_r.flag, exp_r.led, exp_r.tie); else passes++;
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b0;
        cyc(6);
        press_start();
        cyc(1);
        checks++; if (bus.flag !== 4'd1 || bus.tie !== 1'b0) $display("[TB] FAIL tie_cleared: flag %0d tie %b expected 1/0", bus.flag, bus.tie); else passes++;
        bus.btn1 = 1'b1;
        cyc(1);
        bus.btn1 = 1'b0;
        bad = 0;
        n = 0;
        while (bus.led !== 3'b100 && n < 60) begin
            if (bus.flag !== 4'd1 || bus.round_done !== 1'b0) bad++;
            cyc(1);
            n++;
        end
        checks++; if (bad !== 0 || bus.led !== 3'b100) $display("[TB] FAIL glitch_ignored: bad %0d led %b expected 0/100", bad, bus.led); else passes++;
        exp_q.push_back('{flag: 4'd2, led: 3'b100, tie: 1'b0});
        bus.btn1 = 1'b1;
        wait_done(20, n);
        bus.btn1 = 1'b0;
        exp_r = exp_q.pop_front();
        checks++; if (n !== LAT || bus.flag !== exp_r.flag || bus.led !== exp_r.led || bus.tie !== exp_r.tie)
            $display("[TB] FAIL glitch_hit: n %0d got %0d/%b/%b expected %0d %0d/%b/%b", n, bus.flag, bus.led, bus.tie, LAT, exp_r.flag, exp_r.led, exp_r.tie); else passes++;
        cyc(6);
    endtask

    task automatic test_clr_and_reset();
        bit ok;
        press_start();
        wait_go(60, ok);
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        cyc(LAT);
        checks++; if (bus.flag !== 4'd0 || bus.led !== 3'b000 || bus.round_done !== 1'b0)
            $display("[TB] FAIL clr_priority: flag %0d led %b done %b expected 0/000/0", bus.flag, bus.led, bus.round_done); else passes++;
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        cyc(10);
        checks++; if (bus.flag !== 4'd0) $display("[TB] FAIL clr_stays_idle: flag %0d expected 0", bus.flag); else passes++;
        press_start();
        cyc(1);
        checks++; if (bus.flag !== 4'd1 || bus.led !== 3'b001) $display("[TB] FAIL rst_wait_entry: flag %0d led %b expected 1/001", bus.flag, bus.led); else passes++;
        bus.btn1 = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        checks++; if (bus.flag !== 4'd0 || bus.led !== 3'b000) $display("[TB] FAIL rst_mid_round: flag %0d led %b expected 0/000", bus.flag, bus.led); else passes++;
        rst = 1'b1;
        bus.btn1 = 1'b0;
        cyc(12);
        checks++; if (bus.flag !== 4'd0 || bus.tie !== 1'b0 || bus.round_done !== 1'b0)
            $display("[TB] FAIL rst_discard: flag %0d tie %b done %b expected 0/0/0", bus.flag, bus.tie, bus.round_done); else passes++;
    endtask

    initial begin
        test_reset();
        test_arm_delay();
        test_hit();
        test_foul();
        test_timeout();
        test_tie_glitch();
        test_clr_and_reset();
        checks++; if (exp_q.size() !== 0) $display("[TB] FAIL scoreboard_drain: %0d left expected 0", exp_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
